// File: rtl/fibo_pkg.sv
// Shared types, defaults and helpers for the Fibonacci sequence engine.
package fibo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED0,
    SEED1,
    RUN,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_REGS  = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fibo_regfile.sv
// REGS x WIDTH register file: one synchronous write port, two combinational
// read ports, contents cleared asynchronously by rst.
module fibo_regfile
  import fibo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REGS  = DEF_REGS,
  parameter int PW    = clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr_a,
  input  logic [PW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fibo_seq_engine.sv
// Self-sequencing Fibonacci generator: controller, rotating-pointer register
// file, carry-detecting adder with optional saturation, registered outputs.
module fibo_seq_engine
  import fibo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REGS    = DEF_REGS,
  parameter int NTERM_W = 4,
  parameter int SAT     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NTERM_W-1:0] n_terms,
  input  logic [WIDTH-1:0]   seed0,
  input  logic [WIDTH-1:0]   seed1,
  output logic               busy,
  output logic               done,
  output logic               term_valid,
  output logic [WIDTH-1:0]   term,
  output logic [NTERM_W-1:0] term_idx,
  output logic               zero_flag,
  output logic               overflow
);

  localparam int PW = clog2(REGS);

  state_t             state, state_d;
  logic [NTERM_W-1:0] cnt, ridx, ridx_d;
  logic [WIDTH-1:0]   s0_q, s1_q;
  logic [PW-1:0]      wp, wp_d;
  logic               latch;

  logic               we;
  logic [PW-1:0]      waddr;
  logic [WIDTH-1:0]   wdata;
  logic [WIDTH-1:0]   rd_a, rd_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;

  logic               busy_d, done_d, tv_d, zf_d, ov_d;
  logic [WIDTH-1:0]   term_d;
  logic [NTERM_W-1:0] idx_d;

  fibo_regfile #(
    .WIDTH(WIDTH),
    .REGS (REGS),
    .PW   (PW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(wp - PW'(1)),
    .raddr_b(wp - PW'(2)),
    .rdata_a(rd_a),
    .rdata_b(rd_b)
  );

  // Saturated operands carry again on every later add, so saturation persists.
  assign sum = {1'b0, rd_a} + {1'b0, rd_b};
  assign res = ((SAT != 0) && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    latch   = 1'b0;
    wp_d    = wp;
    ridx_d  = ridx;
    we      = 1'b0;
    waddr   = wp;
    wdata   = res;
    busy_d  = busy;
    done_d  = 1'b0;
    tv_d    = 1'b0;
    term_d  = term;
    idx_d   = term_idx;
    ov_d    = overflow;
    unique case (state)
      IDLE: begin
        if (start) begin
          latch  = 1'b1;
          ov_d   = 1'b0;
          wp_d   = PW'(2);
          ridx_d = NTERM_W'(2);
          if (n_terms == '0) begin
            state_d = DONE;
          end else begin
            state_d = SEED0;
            busy_d  = 1'b1;
          end
        end
      end
      SEED0: begin
        we      = 1'b1;
        waddr   = '0;
        wdata   = s0_q;
        tv_d    = 1'b1;
        term_d  = s0_q;
        idx_d   = '0;
        state_d = (cnt == NTERM_W'(1)) ? DONE : SEED1;
      end
      SEED1: begin
        we      = 1'b1;
        waddr   = PW'(1);
        wdata   = s1_q;
        tv_d    = 1'b1;
        term_d  = s1_q;
        idx_d   = NTERM_W'(1);
        state_d = (cnt == NTERM_W'(2)) ? DONE : RUN;
      end
      RUN: begin
        we     = 1'b1;
        tv_d   = 1'b1;
        term_d = res;
        idx_d  = ridx;
        wp_d   = wp + PW'(1);
        ridx_d = ridx + NTERM_W'(1);
        if (sum[WIDTH]) ov_d = 1'b1;
        if (ridx == cnt - NTERM_W'(1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    zf_d = tv_d ? (term_d == '0) : zero_flag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      s0_q <= '0;
      s1_q <= '0;
      wp   <= PW'(2);
      ridx <= NTERM_W'(2);
    end else begin
      if (latch) begin
        cnt  <= n_terms;
        s0_q <= seed0;
        s1_q <= seed1;
      end
      wp   <= wp_d;
      ridx <= ridx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      term_valid <= 1'b0;
      term       <= '0;
      term_idx   <= '0;
      zero_flag  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      term_valid <= tv_d;
      term       <= term_d;
      term_idx   <= idx_d;
      zero_flag  <= zf_d;
      overflow   <= ov_d;
    end
  end

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Directed bench: a wrapping and a saturating instance share stimulus; each
// sequence is compared term by term against hand-computed table values.
module tb_fibo_seq_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] n_terms;
  logic [7:0] seed0, seed1;

  logic       busy_w, done_w, tv_w, zf_w, ov_w;
  logic [7:0] term_w;
  logic [3:0] idx_w;
  logic       busy_s, done_s, tv_s, zf_s, ov_s;
  logic [7:0] term_s;
  logic [3:0] idx_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fibo_seq_engine #(.WIDTH(8), .REGS(4), .NTERM_W(4), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
    .seed0(seed0), .seed1(seed1), .busy(busy_w), .done(done_w),
    .term_valid(tv_w), .term(term_w), .term_idx(idx_w),
    .zero_flag(zf_w), .overflow(ov_w)
  );

  fibo_seq_engine #(.WIDTH(8), .REGS(4), .NTERM_W(4), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
    .seed0(seed0), .seed1(seed1), .busy(busy_s), .done(done_s),
    .term_valid(tv_s), .term(term_s), .term_idx(idx_s),
    .zero_flag(zf_s), .overflow(ov_s)
  );

  typedef struct {
    int n;
    int s0;
    int s1;
    int poke;    // term index after which a spurious start is pulsed, -1 none
    int last_w;  // hand-computed final term, wrapping instance
    int last_s;  // hand-computed final term, saturating instance
    int ovf;     // expected sticky overflow after the sequence (both)
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy_w"}, int'(busy_w), 0);
    chk({tag, " done_w"}, int'(done_w), 0);
    chk({tag, " tv_w"},   int'(tv_w), 0);
    chk({tag, " term_w"}, int'(term_w), 0);
    chk({tag, " idx_w"},  int'(idx_w), 0);
    chk({tag, " zf_w"},   int'(zf_w), 0);
    chk({tag, " ov_w"},   int'(ov_w), 0);
    chk({tag, " busy_s"}, int'(busy_s), 0);
    chk({tag, " term_s"}, int'(term_s), 0);
    chk({tag, " ov_s"},   int'(ov_s), 0);
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    int p1w, p2w, p1s, p2s, ew, es, ovw, ovs, sm;
    ovw = 0; ovs = 0; p1w = 0; p2w = 0; p1s = 0; p2s = 0;
    start   = 1'b1;
    n_terms = 4'(v.n);
    seed0   = 8'(v.s0);
    seed1   = 8'(v.s1);
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("%s E0 busy", tag), int'(busy_w), (v.n != 0) ? 1 : 0);
    chk($sformatf("%s E0 busy_s", tag), int'(busy_s), (v.n != 0) ? 1 : 0);
    chk($sformatf("%s E0 tv", tag), int'(tv_w), 0);
    chk($sformatf("%s E0 ov cleared", tag), int'(ov_w) + int'(ov_s), 0);
    for (int k = 0; k < v.n; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 0) begin
        ew = v.s0; es = v.s0;
      end else if (k == 1) begin
        ew = v.s1; es = v.s1;
      end else begin
        sm = p1w + p2w;
        if (sm > 255) ovw = 1;
        ew = sm % 256;
        sm = p1s + p2s;
        if (sm > 255) begin ovs = 1; es = 255; end
        else es = sm;
      end
      p2w = p1w; p1w = ew; p2s = p1s; p1s = es;
      chk($sformatf("%s k%0d tv", tag, k), int'(tv_w) + int'(tv_s), 2);
      chk($sformatf("%s k%0d idx", tag, k), int'(idx_w), k);
      chk($sformatf("%s k%0d idx_s", tag, k), int'(idx_s), k);
      chk($sformatf("%s k%0d term_w", tag, k), int'(term_w), ew);
      chk($sformatf("%s k%0d term_s", tag, k), int'(term_s), es);
      chk($sformatf("%s k%0d zf", tag, k), int'(zf_w), (ew == 0) ? 1 : 0);
      chk($sformatf("%s k%0d ov_w", tag, k), int'(ov_w), ovw);
      chk($sformatf("%s k%0d ov_s", tag, k), int'(ov_s), ovs);
      chk($sformatf("%s k%0d busy", tag, k), int'(busy_w), 1);
      chk($sformatf("%s k%0d done", tag, k), int'(done_w), 0);
      if (k == v.poke) begin
        start   = 1'b1;
        n_terms = 4'd3;
        seed0   = 8'd77;
        seed1   = 8'd99;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("%s done", tag), int'(done_w) + int'(done_s), 2);
    chk($sformatf("%s done tv", tag), int'(tv_w), 0);
    chk($sformatf("%s done busy", tag), int'(busy_w) + int'(busy_s), 0);
    @(posedge clk); #1;
    chk($sformatf("%s post done", tag), int'(done_w), 0);
    chk($sformatf("%s post tv", tag), int'(tv_w), 0);
    if (v.n > 0) begin
      chk($sformatf("%s hold term_w", tag), int'(term_w), v.last_w);
      chk($sformatf("%s hold term_s", tag), int'(term_s), v.last_s);
      chk($sformatf("%s hold idx", tag), int'(idx_w), v.n - 1);
    end
    chk($sformatf("%s sticky ov_w", tag), int'(ov_w), v.ovf);
    chk($sformatf("%s sticky ov_s", tag), int'(ov_s), v.ovf);
  endtask

  initial begin
    tbl[0] = '{n: 8,  s0: 0,   s1: 1,   poke: -1, last_w: 13,  last_s: 13,  ovf: 0};
    tbl[1] = '{n: 15, s0: 0,   s1: 1,   poke: -1, last_w: 121, last_s: 255, ovf: 1};
    tbl[2] = '{n: 0,  s0: 9,   s1: 9,   poke: -1, last_w: 0,   last_s: 0,   ovf: 0};
    tbl[3] = '{n: 1,  s0: 5,   s1: 9,   poke: -1, last_w: 5,   last_s: 5,   ovf: 0};
    tbl[4] = '{n: 2,  s0: 3,   s1: 4,   poke: -1, last_w: 4,   last_s: 4,   ovf: 0};
    tbl[5] = '{n: 12, s0: 100, s1: 200, poke: -1, last_w: 4,   last_s: 255, ovf: 1};
    tbl[6] = '{n: 10, s0: 0,   s1: 1,   poke: 4,  last_w: 34,  last_s: 34,  ovf: 0};

    rst = 1'b1; start = 1'b0; n_terms = '0; seed0 = '0; seed1 = '0;
    #12;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_seq(tbl[i], $sformatf("v%0d", i));

    // asynchronous reset mid-run, after overflow has been raised
    start = 1'b1; n_terms = 4'd12; seed0 = 8'd100; seed1 = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("pre-rst ov", int'(ov_w), 1);
    rst = 1'b1;
    #1;
    chk_zero("midrun rst");
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("after rst");
    run_seq('{n: 4, s0: 2, s1: 3, poke: -1, last_w: 8, last_s: 8, ovf: 0}, "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fibo_seq_engine.md
# fibo_seq_engine

Self-sequencing Fibonacci generator: a parametrised register file, an adder with carry detection and an internal controller. It emits a requested number of terms from two programmable seeds over a start/done handshake. It generalises the fixed 4-bit, 4-register Fibonacci datapath, which needs an external controller. Rotating read/write pointers replace externally driven addresses, and the block adds overflow detection and an optional saturating mode.

## Interface
- WIDTH, 8, term/seed width in bits (≥2)
- REGS, 4, register-file depth; power of two, ≥4
- NTERM_W, 4, width of the term-count input
- SAT, 0, 0 = results wrap modulo 2^WIDTH; 1 = results saturate at all-ones
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- n_terms  in  NTERM_W  number of terms to emit; latched with start
- seed0, seed1  in  WIDTH each  first two terms; latched with start
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- term_valid  out  1  term/term_idx valid this cycle
- term  out  WIDTH  current term
- term_idx  out  NTERM_W  index of current term, 0-based
- zero_flag  out  1  term == 0, registered with term
- overflow  out  1  sticky; an addition carried out of WIDTH since last accepted start

## Operation
- States: IDLE, SEED0, SEED1, RUN, DONE (enum in package).
- IDLE: start=1 latches n_terms (cnt), seed0 and seed1, and clears overflow.
  - n_terms=0 → DONE.
  - Otherwise → SEED0.
- SEED0: write seed0 to reg[0] and emit it as term 0.
  - cnt=1 → DONE; else → SEED1.
- SEED1: write seed1 to reg[1] and emit it as term 1.
  - cnt=2 → DONE; else → RUN.
- RUN, one term per cycle:
  - sum = reg[wp-1] + reg[wp-2], with pointers mod REGS; wp starts at 2.
  - Write sum to reg[wp] and emit it; wp increments and wraps REGS-1→0.
  - → DONE after emitting idx cnt-1.
- Adder is WIDTH+1 bits wide. Carry=1 sets overflow.
  - SAT=0: stored and emitted value is sum[WIDTH-1:0].
  - SAT=1: stored and emitted value is all-ones. Later sums keep saturating from saturated operands.
- DONE: lasts one cycle with done=1, then → IDLE. start is ignored in DONE.
- start while busy (SEED0/SEED1/RUN) is ignored: latched values and sequence are unaffected.
- Reset, at any time including mid-sequence:
  - state=IDLE, wp=2.
  - All outputs 0: busy, done, term_valid, term, term_idx, zero_flag, overflow.
  - Register-file contents cleared to 0.

## Timing
- All outputs registered. No combinational path from inputs to outputs.
- Edge E0 samples start in IDLE. From E0: busy=1, except the n_terms=0 case, where E1 gives done=1 and busy stays 0.
- Edge E(k+1) presents term k (term_valid=1, term_idx=k, zero_flag) for one cycle, k = 0..n-1.
  - Seed latency 1 cycle; throughput 1 term/cycle.
- Edge E(n+1): term_valid=0, busy=0, done=1.
- Edge E(n+2): done=0. Earliest next accepted start is sampled at E(n+2).
- overflow rises at the same edge as the first overflowing term. It holds through done and IDLE until the next accepted start or rst.
- term/term_idx hold their last values while term_valid=0. Only reset clears them.

## Structure
- Package fibo_pkg holds:
  - state enum (IDLE, SEED0, SEED1, RUN, DONE);
  - pointer-width localparam function clog2(REGS);
  - shared defaults for WIDTH/REGS.
- Sub-module fibo_regfile: REGS×WIDTH, one synchronous write port, two combinational read ports, asynchronous clear on rst. Parameters WIDTH and REGS.
- Top-level fibo_seq_engine contains:
  - FSM, term counter and pointer logic;
  - (WIDTH+1)-bit adder;
  - saturation mux and output registers.

## Test plan
- Basic sequence, WIDTH=8, seeds 0/1, n=8: terms 0,1,1,2,3,5,8,13 on E1..E8 with idx 0..7; zero_flag=1 only on idx 0; done at E9; overflow=0.
- Wrap mode and pointer wrap, WIDTH=8, REGS=4, seeds 0/1, n=15:
  - idx 13 = 233;
  - idx 14 = 121 (377 mod 256), with overflow=1 from that edge;
  - overflow still 1 after done.
- Same stimulus with SAT=1: idx 14 = 255 with overflow=1. A new start clears overflow to 0.
- Edge counts:
  - n=0: done at E1, term_valid never asserted.
  - n=1, seed0=5: single term 5, done at E2.
  - n=2, seeds 3/4: terms 3,4, done at E3.
- start pulsed with new seeds mid-RUN: sequence continues unchanged.
- rst asserted asynchronously mid-RUN (between edges): all outputs 0 immediately. After release, a fresh start with seeds 2/3, n=4 yields 2,3,5,8.
